adc_avg_win: RTL and testbench

- Parametrised windowed averager for the ADC sample path. It sits between the ADC sampling front end and the voltage display/UART logic.
- Accumulates exactly 2^LOG2_N valid samples and outputs a scaled mean with optional rounding. Also tracks the window minimum and maximum.
- Supports single-shot or continuous gap-free windows, plus abort.

---
 rtl/adc_avg_win.sv | 104 ++++++++++
 tb/tb_adc_avg_win.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/adc_avg_win.sv
// adc_avg_win: windowed averager over 2^LOG2_N ADC samples with min/max tracking,
// single-shot or gap-free continuous windows, abort, and optional round-half-up.
module adc_avg_win #(
    parameter int DIN_W  = 8,
    parameter int LOG2_N = 24,
    parameter int OUT_W  = 12,
    parameter int ROUND  = 0
) (
    input  logic              s_clk,
    input  logic              s_rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    input  logic              din_vld,
    input  logic [DIN_W-1:0]  din,
    output logic              busy,
    output logic [LOG2_N-1:0] win_cnt,
    output logic [OUT_W-1:0]  avg,
    output logic [DIN_W-1:0]  min_val,
    output logic [DIN_W-1:0]  max_val,
    output logic              avg_vld
);
    localparam int ACC_W = DIN_W + LOG2_N;

    typedef enum logic {IDLE, ACC} state_t;

    state_t            state, state_n;
    logic [ACC_W-1:0]  acc, sum_n, stg_sum;
    logic [DIN_W-1:0]  run_min, run_max, min_n, max_n, stg_min, stg_max;
    logic [OUT_W-1:0]  avg_n;
    logic              stg_vld, go, take, last;

    always_comb begin
        go      = state == IDLE && start && !abort;
        take    = state == ACC && din_vld && !abort;
        last    = take && win_cnt == '1;
        sum_n   = acc + ACC_W'(din);
        min_n   = din < run_min ? din : run_min;
        max_n   = din > run_max ? din : run_max;
        state_n = state;
        if (go)
            state_n = ACC;
        else if (state == ACC && (abort || (last && !cont)))
            state_n = IDLE;
    end

    // Window registers clear on the final sample too, so continuous mode starts
    // the next window on the very next strobe without losing a sample.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            acc     <= '0;
            win_cnt <= '0;
            run_min <= '1;
            run_max <= '0;
            stg_vld <= 1'b0;
            stg_sum <= '0;
            stg_min <= '0;
            stg_max <= '0;
            avg_vld <= 1'b0;
            avg     <= '0;
            min_val <= '0;
            max_val <= '0;
        end else begin
            state   <= state_n;
            busy    <= state_n == ACC;
            if (go || last) begin
                acc     <= '0;
                win_cnt <= '0;
                run_min <= '1;
                run_max <= '0;
            end else if (take) begin
                acc     <= sum_n;
                win_cnt <= win_cnt + 1'b1;
                run_min <= min_n;
                run_max <= max_n;
            end
            stg_vld <= last;
            if (last) begin
                stg_sum <= sum_n;
                stg_min <= min_n;
                stg_max <= max_n;
            end
            avg_vld <= stg_vld;
            if (stg_vld) begin
                avg     <= avg_n;
                min_val <= stg_min;
                max_val <= stg_max;
            end
        end
    end

    if (ROUND != 0 && ACC_W > OUT_W) begin : g_rnd
        localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (ACC_W - OUT_W - 1);
        logic [ACC_W:0] t;
        always_comb begin
            t     = {1'b0, stg_sum} + HALF;
            avg_n = t[ACC_W] ? '1 : t[ACC_W-1 -: OUT_W];
        end
    end else begin : g_trn
        always_comb avg_n = stg_sum[ACC_W-1 -: OUT_W];
    end
endmodule

// File: tb/tb_adc_avg_win.sv
// tb_adc_avg_win: truncating and rounding averagers driven in parallel, checked
// against a window model that queues expected results for the output monitor.
module tb_adc_avg_win;
    logic       clk = 1'b0, rst_n = 1'b1;
    logic       start = 1'b0, cont = 1'b0, abort = 1'b0, din_vld = 1'b0;
    logic [7:0] din = '0;
    logic       busy_t, busy_r, vld_t, vld_r;
    logic [1:0] wc_t, wc_r;
    logic [7:0] avg_t, avg_r, mn_t, mn_r, mx_t, mx_r;

    int checks = 0, failures = 0, cyc = 0;

    typedef struct {int at; int ar; int mn; int mx; int c;} exp_t;
    exp_t q[$];
    bit m_act = 0;
    int m_cnt = 0, m_sum = 0, m_min = 255, m_max = 0;

    adc_avg_win #(.DIN_W(8), .LOG2_N(2), .OUT_W(8), .ROUND(0)) dut_t (
        .s_clk(clk), .s_rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
        .din_vld(din_vld), .din(din), .busy(busy_t), .win_cnt(wc_t), .avg(avg_t),
        .min_val(mn_t), .max_val(mx_t), .avg_vld(vld_t));

    adc_avg_win #(.DIN_W(8), .LOG2_N(2), .OUT_W(8), .ROUND(1)) dut_r (
        .s_clk(clk), .s_rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
        .din_vld(din_vld), .din(din), .busy(busy_r), .win_cnt(wc_r), .avg(avg_r),
        .min_val(mn_r), .max_val(mx_r), .avg_vld(vld_r));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic st, input logic ab);
        exp_t e;
        @(negedge clk);
        din_vld = v; din = d; start = st; abort = ab;
        if (!m_act) begin
            if (st && !ab) begin
                m_act = 1; m_cnt = 0; m_sum = 0; m_min = 255; m_max = 0;
            end
        end else if (ab) begin
            m_act = 0;
        end else if (v) begin
            m_sum += int'(d);
            m_cnt++;
            if (int'(d) < m_min) m_min = int'(d);
            if (int'(d) > m_max) m_max = int'(d);
            if (m_cnt == 4) begin
                e.at = m_sum / 4;
                e.ar = (m_sum + 2) > 1023 ? 255 : (m_sum + 2) / 4;
                e.mn = m_min;
                e.mx = m_max;
                e.c  = cyc + 2;
                q.push_back(e);
                m_act = cont; m_cnt = 0; m_sum = 0; m_min = 255; m_max = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n && (vld_t || vld_r)) begin : mon
            exp_t e;
            chk("vld_match", vld_r, vld_t);
            if (q.size() == 0) chk("unexpected_vld", q.size(), 1);
            else begin
                e = q.pop_front();
                chk("avg_trunc", avg_t, e.at);
                chk("avg_round", avg_r, e.ar);
                chk("min_t", mn_t, e.mn);
                chk("max_t", mx_t, e.mx);
                chk("min_r", mn_r, e.mn);
                chk("max_r", mx_r, e.mx);
                chk("latency", cyc, e.c);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy_t, 0);
        chk("rst_wc", wc_t, 0);
        chk("rst_avg", avg_t, 0);
        chk("rst_min", mn_r, 0);
        chk("rst_max", mx_r, 0);
        chk("rst_vld", vld_t, 0);
        rst_n = 1'b1;
        // single-shot window, then ignored samples in IDLE
        step(0, 0, 1, 0);
        step(1, 10, 0, 0);
        chk("busy_acc", busy_t, 1);
        step(1, 11, 0, 0);
        step(1, 11, 0, 0);
        step(1, 11, 0, 0);
        idle(3);
        chk("busy_drop", busy_t, 0);
        step(1, 77, 0, 0);
        step(1, 77, 0, 0);
        idle(3);
        // full-scale window must not wrap in rounding mode
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 255, 0, 0);
        idle(3);
        // continuous back-to-back windows
        cont = 1'b1;
        step(0, 0, 1, 0);
        for (int i = 0; i < 12; i++) begin
            if (i == 11) cont = 1'b0;
            step(1, 8'(i), 0, 0);
            if (i > 0) chk("busy_cont", busy_r, 1);
        end
        idle(4);
        chk("busy_cont_end", busy_t, 0);
        // abort coincident with the final sample
        step(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 50, 0, 0);
        step(1, 50, 0, 1);
        step(0, 0, 0, 0);
        chk("busy_abort", busy_t, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 200, 0, 0);
        idle(3);
        // gapped strobes with a start while busy
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, i == 2, 0);
            idle(int'($urandom_range(0, 3)));
            chk("win_cnt", wc_t, i);
            step(1, 8'(4 * (i + 1)), 0, 0);
        end
        idle(3);
        // abort and start together in IDLE
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);
        chk("busy_abort_start", busy_t, 0);
        // reset in the middle of a window
        step(0, 0, 1, 0);
        step(1, 30, 0, 0);
        step(1, 40, 0, 0);
        step(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        m_act = 0;
        #1;
        chk("mid_rst_busy", busy_t, 0);
        chk("mid_rst_wc", wc_r, 0);
        chk("mid_rst_avg", avg_t, 0);
        chk("mid_rst_min", mn_t, 0);
        chk("mid_rst_max", mx_r, 0);
        chk("mid_rst_vld", vld_r, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
